instmem_loader: RTL
===================

Name: instmem_loader

Overview:
- Program loader that writes the byte-wide instruction memory from a byte stream. It is the write side of the instruction ROM.
- Accepts a 2-byte length header followed by payload bytes over a valid/ready stream. Payload bytes are written sequentially from the ROM base address.
- Holds the CPU in reset while loading.
- Sits between the host/UART byte receiver and the instruction memory's byte write port.

Parameters:
- ADDR_WIDTH, 12, byte-offset width inside instruction memory; capacity = 2^ADDR_WIDTH bytes.
- STORAGE_WIDTH, 8, memory cell width; the stream byte width is equal to it.
- BASE_ADDR, 32'hBFC00000, absolute address of the first payload byte.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a load; sampled in IDLE, DONE and ERR.
- in_valid  input  1  stream byte valid.
- in_data  input  STORAGE_WIDTH  stream byte.
- in_ready  output  1  loader accepts in_data this cycle.
- mem_we  output  1  byte write strobe to instruction memory.
- mem_addr  output  32  absolute write address.
- mem_wdata  output  STORAGE_WIDTH  write byte.
- busy  output  1  load in progress.
- done  output  1  load completed successfully (level).
- error  output  1  header length exceeded capacity (level).
- cpu_rst  output  1  CPU reset hold.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, error=0, cpu_rst=1; byte counter and length cleared.
- A transfer occurs on a rising edge with in_valid&in_ready.
- in_ready=1 only in LEN_HI, LEN_LO and DATA; in_data is ignored in every other state.
- States:
  - IDLE: start=1 -> LEN_HI.
  - LEN_HI: on transfer, len[15:8]=in_data -> LEN_LO.
  - LEN_LO: on transfer, len[7:0]=in_data.
    - len==0 -> DONE.
    - len>2^ADDR_WIDTH -> ERR.
    - otherwise idx=0 -> DATA.
  - DATA: on each transfer, register mem_we=1, mem_addr=BASE_ADDR+idx, mem_wdata=in_data for exactly the next cycle; idx++.
    - After the len-th transfer: len%4==0 -> DONE, else -> PAD.
  - PAD: one zero byte per cycle (mem_we=1, mem_wdata=0, address continues at idx) until idx%4==0 -> DONE. in_ready=0.
  - DONE: done=1, cpu_rst=0, busy=0; start=1 -> LEN_HI, clearing done and raising cpu_rst the following cycle.
  - ERR: error=1, cpu_rst=1, nothing written; start=1 -> LEN_HI, clearing error.
- busy=1 in LEN_HI, LEN_LO, DATA and PAD.
- cpu_rst=1 in every state except DONE.
- Timing:
  - Write latency is 1 cycle after the accepting edge.
  - Maximum rate is 1 byte/cycle.
  - in_valid gaps in DATA insert mem_we=0 cycles; address does not advance.
- Arithmetic:
  - idx is ADDR_WIDTH+1 bits wide.
  - mem_addr = BASE_ADDR + zero-extended idx[ADDR_WIDTH-1:0].
  - len==2^ADDR_WIDTH is legal; the last byte lands at BASE_ADDR+2^ADDR_WIDTH-1, and there is no wrap.
- Byte order: payload byte k goes to offset k. A word at offset a is therefore fetched as {b[a],b[a+1],b[a+2],b[a+3]}, i.e. the stream is big-endian per word.
- start is ignored while busy.
- start together with a transfer in DONE: the byte is not accepted, because in_ready=0 in DONE.
- Reset mid-load: returns to IDLE at once. Already-written bytes are not cleared. cpu_rst stays 1.
- mem_we is never asserted outside DATA/PAD-originated cycles.

Test Plan:
1. Reset then start, stream 00 08 01 02 03 04 05 06 07 08 at full rate.
   - Required: 8 writes, bytes 01..08, to BFC00000..BFC00007 on consecutive cycles.
   - Required: done=1 and cpu_rst=0 one cycle after the last write.
2. Header 00 05, payload AA BB CC DD EE.
   - Required: 5 data writes.
   - Required: zero writes at BFC00005, BFC00006 and BFC00007.
   - Required: then done.
3. Header 10 01 (4097 > 4096).
   - Required: error=1, cpu_rst=1, no mem_we ever.
   - Required: a subsequent start with header 00 00 gives done=1 and error=0.
4. Header 00 04 with in_valid toggling 1,0,0,1,1,0,1.
   - Required: exactly 4 writes to BFC00000..3 in order.
   - Required: mem_we low during gaps; in_ready low only after DONE.
5. Assert rst after the 3rd payload byte of a 16-byte load.
   - Required: outputs return to reset values asynchronously, with no further writes.
   - Required: a restart loads correctly from BFC00000.
6. Header 10 00 (4096 bytes) of incrementing data.
   - Required: last write is BFC00FFF with byte FF.
   - Required: no address wrap, no PAD, done=1.

Source files
------------

// File: rtl/instmem_loader.sv
// Byte-stream program loader: takes a 16-bit big-endian length header, then writes
// payload bytes sequentially from BASE_ADDR, zero-padding to a word boundary.
module instmem_loader #(
  parameter int          ADDR_WIDTH    = 12,
  parameter int          STORAGE_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR     = 32'hBFC00000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [STORAGE_WIDTH-1:0] in_data,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [STORAGE_WIDTH-1:0] mem_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     cpu_rst,
  output logic [2:0]               dbg_state
);

  // Stream handshake: a byte moves on a rising edge where in_valid & in_ready;
  // in_ready depends only on the state, never on in_valid.

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PAD    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam int          IW  = ADDR_WIDTH + 1;
  localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;

  logic [2:0]               r_state;
  logic [IW-1:0]            r_idx;
  logic [15:0]              r_len;
  logic                     r_mem_we;
  logic [31:0]              r_mem_addr;
  logic [STORAGE_WIDTH-1:0] r_mem_wdata;

  logic [IW-1:0]            w_idx_next;
  logic [15:0]              w_len_full;
  logic [31:0]              w_idx_addr;
  logic                     w_xfer;
  logic                     w_last_data;

  assign w_idx_next  = r_idx + IW'(1);
  assign w_len_full  = {r_len[15:8], in_data[7:0]};
  // idx never exceeds the capacity, so only its low bits form the offset.
  assign w_idx_addr  = BASE_ADDR + 32'(r_idx[ADDR_WIDTH-1:0]);
  assign w_xfer      = in_valid && in_ready;
  assign w_last_data = (17'(w_idx_next) == 17'(r_len));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_len       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= BASE_ADDR;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) r_state <= S_LEN_HI;
        end
        S_LEN_HI: begin
          if (w_xfer) begin
            r_len[15:8] <= in_data[7:0];
            r_state     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_xfer) begin
            r_len[7:0] <= in_data[7:0];
            r_idx      <= '0;
            if (w_len_full == 16'd0)             r_state <= S_DONE;
            else if (17'(w_len_full) > CAP)      r_state <= S_ERR;
            else                                 r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_idx_addr;
            r_mem_wdata <= in_data;
            r_idx       <= w_idx_next;
            if (w_last_data) r_state <= (r_len[1:0] == 2'b00) ? S_DONE : S_PAD;
          end
        end
        S_PAD: begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= w_idx_addr;
          r_mem_wdata <= '0;
          r_idx       <= w_idx_next;
          if (w_idx_next[1:0] == 2'b00) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) || (r_state == S_DATA);
  assign busy      = in_ready || (r_state == S_PAD);
  assign done      = (r_state == S_DONE);
  assign error     = (r_state == S_ERR);
  assign cpu_rst   = (r_state != S_DONE);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign dbg_state = r_state;

endmodule
